// File: rtl/bus_timer_array.sv
// Multi-channel memory-mapped interval timer on the 8-bit processor bus.
// Shared prescaler tick drives NUM_CH 16-bit counters; fires set PEND and may raise the interrupt.
module bus_timer_array #(
  parameter logic [7:0]  BASE_ADDR = 8'hF0,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned PRESCALE  = 50000
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);

  localparam int unsigned PsW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [3:0]  ChMask = 4'((1 << NUM_CH) - 1);

  logic [PsW-1:0] presc_q;
  logic           tick;

  logic [3:0]  en_q, en_d;
  logic [3:0]  periodic_q, periodic_d;
  logic [3:0]  pend_q, pend_d;
  logic [3:0]  mask_q, mask_d;
  logic [3:0]  fire;
  logic [15:0] period_q [4];
  logic [15:0] period_d [4];
  logic [15:0] count_q  [4];
  logic [15:0] count_d  [4];

  logic       hit, wr, rd;
  logic [3:0] off;
  logic [2:0] pch;
  logic [7:0] wdata;
  logic [7:0] rd_data_q, rd_data_d;
  logic       rd_valid_q;
  logic       irq_event;

  assign hit   = (BUS_ADDR[7:4] == BASE_ADDR[7:4]);
  assign wr    = hit & BUS_WE;
  assign rd    = hit & ~BUS_WE;
  assign off   = BUS_ADDR[3:0];
  assign pch   = off[3:1] - 3'd2;  // offsets 0x4..0xB map to period channel 0..3
  assign wdata = BUS_DATA;

  assign BUS_DATA = rd_valid_q ? rd_data_q : 8'hzz;

  assign tick      = (presc_q == PsW'(PRESCALE - 1));
  assign irq_event = |(fire & mask_q);

  always_comb begin
    en_d       = en_q;
    periodic_d = periodic_q;
    mask_d     = mask_q;
    pend_d     = pend_q;
    period_d   = period_q;
    count_d    = count_q;
    fire       = '0;

    for (int i = 0; i < 4; i++) begin
      if (ChMask[i] && tick && en_q[i] && (period_q[i] != 16'd0)) begin
        if (count_q[i] == period_q[i] - 16'd1) begin
          fire[i]    = 1'b1;
          count_d[i] = '0;
          if (!periodic_q[i]) en_d[i] = 1'b0;
        end else begin
          count_d[i] = count_q[i] + 16'd1;
        end
      end
    end

    // Bus writes are applied last so they override counting and one-shot auto-disable.
    if (wr) begin
      case (off)
        4'h0: begin
          en_d       = wdata[3:0] & ChMask;
          periodic_d = wdata[7:4] & ChMask;
          for (int i = 0; i < 4; i++) begin
            if (ChMask[i] && wdata[i] && !en_q[i]) count_d[i] = '0;
          end
        end
        4'h1:    pend_d = pend_q & ~wdata[3:0];
        4'h2:    mask_d = wdata[3:0] & ChMask;
        default: begin
          if ((off >= 4'h4) && (off <= 4'hB) && (32'(pch) < NUM_CH)) begin
            if (off[0]) period_d[pch[1:0]][15:8] = wdata;
            else        period_d[pch[1:0]][7:0]  = wdata;
            count_d[pch[1:0]] = '0;
          end
        end
      endcase
    end

    // A fire in the same cycle as a W1C keeps the flag set.
    pend_d = pend_d | fire;
  end

  always_comb begin
    rd_data_d = '0;
    case (off)
      4'h0: rd_data_d = {periodic_q, en_q};
      4'h1: rd_data_d = {4'h0, pend_q};
      4'h2: rd_data_d = {4'h0, mask_q};
      4'hC, 4'hD, 4'hE, 4'hF: begin
        if (32'(off[1:0]) < NUM_CH) rd_data_d = count_q[off[1:0]][7:0];
      end
      default: begin
        if ((off >= 4'h4) && (32'(pch) < NUM_CH)) begin
          rd_data_d = off[0] ? period_q[pch[1:0]][15:8] : period_q[pch[1:0]][7:0];
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      presc_q             <= '0;
      en_q                <= '0;
      periodic_q          <= '0;
      pend_q              <= '0;
      mask_q              <= '0;
      rd_data_q           <= '0;
      rd_valid_q          <= 1'b0;
      BUS_INTERRUPT_RAISE <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        period_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      presc_q             <= tick ? '0 : presc_q + 1'b1;
      en_q                <= en_d;
      periodic_q          <= periodic_d;
      pend_q              <= pend_d;
      mask_q              <= mask_d;
      rd_valid_q          <= rd;
      rd_data_q           <= rd ? rd_data_d : '0;
      BUS_INTERRUPT_RAISE <= irq_event | (BUS_INTERRUPT_RAISE & ~BUS_INTERRUPT_ACK);
      for (int i = 0; i < 4; i++) begin
        period_q[i] <= period_d[i];
        count_q[i]  <= count_d[i];
      end
    end
  end

endmodule

// File: tb/tb_bus_timer_array.sv
// Bench for bus_timer_array: two instances (4-channel at 0xF0, 2-channel at 0xE0) on one bus,
// checked against a cycle-level behavioural model through a read scoreboard.
module tb_bus_timer_array;

  localparam int unsigned Pre = 4;
  localparam int          ND  = 2;

  logic       clk = 1'b0;
  logic       reset, bus_we, ack, tb_drv;
  logic [7:0] bus_addr, tb_wdata;
  wire  [7:0] bus_data;
  logic       raise0, raise1;

  always #5 clk = ~clk;

  assign bus_data = tb_drv ? tb_wdata : 8'hzz;

  bus_timer_array #(.BASE_ADDR(8'hF0), .NUM_CH(4), .PRESCALE(Pre)) dut0 (
    .CLK(clk), .RESET(reset), .BUS_DATA(bus_data), .BUS_ADDR(bus_addr), .BUS_WE(bus_we),
    .BUS_INTERRUPT_RAISE(raise0), .BUS_INTERRUPT_ACK(ack)
  );

  bus_timer_array #(.BASE_ADDR(8'hE0), .NUM_CH(2), .PRESCALE(Pre)) dut1 (
    .CLK(clk), .RESET(reset), .BUS_DATA(bus_data), .BUS_ADDR(bus_addr), .BUS_WE(bus_we),
    .BUS_INTERRUPT_RAISE(raise1), .BUS_INTERRUPT_ACK(ack)
  );

  typedef struct {
    int         due;
    logic [7:0] addr;
    logic [7:0] exp;
  } rd_t;

  rd_t        sbq[$];
  logic [7:0] base[ND] = '{8'hF0, 8'hE0};
  int         nch[ND]  = '{4, 2};
  int         m_pcnt[ND];
  int         m_period[ND][4];
  int         m_count[ND][4];
  bit         m_en[ND][4], m_per[ND][4], m_pend[ND][4], m_mask[ND][4];
  bit         m_raise[ND];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;

  function automatic void chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  function automatic logic [7:0] mread(int d, int off);
    logic [7:0] v = '0;
    int ch;
    if (off == 0) begin
      for (int i = 0; i < 4; i++) begin v[i] = m_en[d][i]; v[4+i] = m_per[d][i]; end
    end else if (off == 1) begin
      for (int i = 0; i < 4; i++) v[i] = m_pend[d][i];
    end else if (off == 2) begin
      for (int i = 0; i < 4; i++) v[i] = m_mask[d][i];
    end else if (off >= 4 && off < 12) begin
      ch = (off - 4) / 2;
      if (ch < nch[d]) v = (off % 2 == 1) ? 8'(m_period[d][ch] >> 8) : 8'(m_period[d][ch]);
    end else if (off >= 12) begin
      ch = off - 12;
      if (ch < nch[d]) v = 8'(m_count[d][ch]);
    end
    return v;
  endfunction

  function automatic bit will_fire(int d, int ch);
    return (m_pcnt[d] == Pre - 1) && m_en[d][ch] && (m_period[d][ch] != 0) &&
           (m_count[d][ch] == m_period[d][ch] - 1);
  endfunction

  // Behavioural model: advances every device by one clock edge with the given bus inputs.
  task automatic model_step(bit rst, bit we, logic [7:0] addr, logic [7:0] wd, bit ak);
    bit  tick, hit, ev;
    bit  fire[4], en_old[4], mask_old[4];
    int  off, n, ch;
    rd_t e;
    cyc++;
    for (int d = 0; d < ND; d++) begin
      if (rst) begin
        m_pcnt[d]  = 0;
        m_raise[d] = 0;
        for (int i = 0; i < 4; i++) begin
          m_period[d][i] = 0; m_count[d][i] = 0; m_en[d][i] = 0;
          m_per[d][i] = 0; m_pend[d][i] = 0; m_mask[d][i] = 0;
        end
      end else begin
        n    = nch[d];
        off  = int'(addr[3:0]);
        hit  = (addr[7:4] == base[d][7:4]);
        tick = (m_pcnt[d] == Pre - 1);
        m_pcnt[d] = tick ? 0 : m_pcnt[d] + 1;
        if (hit && !we) begin
          e.due = cyc; e.addr = addr; e.exp = mread(d, off);
          sbq.push_back(e);
        end
        ev = 0;
        for (int i = 0; i < 4; i++) begin
          en_old[i]   = m_en[d][i];
          mask_old[i] = m_mask[d][i];
          fire[i]     = (i < n) && tick && will_fire_now(d, i);
          if ((i < n) && tick && m_en[d][i] && m_period[d][i] != 0) begin
            if (fire[i]) begin
              m_count[d][i] = 0;
              if (!m_per[d][i]) m_en[d][i] = 0;
            end else begin
              m_count[d][i]++;
            end
          end
          ev |= fire[i] && mask_old[i];
        end
        if (hit && we) begin
          if (off == 0) begin
            for (int i = 0; i < n; i++) begin
              if (wd[i] && !en_old[i]) m_count[d][i] = 0;
              m_en[d][i]  = wd[i];
              m_per[d][i] = wd[4+i];
            end
          end else if (off == 1) begin
            for (int i = 0; i < n; i++) if (wd[i]) m_pend[d][i] = 0;
          end else if (off == 2) begin
            for (int i = 0; i < n; i++) m_mask[d][i] = wd[i];
          end else if (off >= 4 && off < 12) begin
            ch = (off - 4) / 2;
            if (ch < n) begin
              if (off % 2 == 1) m_period[d][ch] = (m_period[d][ch] & 'hFF) | (int'(wd) << 8);
              else              m_period[d][ch] = (m_period[d][ch] & 'hFF00) | int'(wd);
              m_count[d][ch] = 0;
            end
          end
        end
        for (int i = 0; i < 4; i++) if (fire[i]) m_pend[d][i] = 1;
        m_raise[d] = ev ? 1'b1 : (ak ? 1'b0 : m_raise[d]);
      end
    end
  endtask

  function automatic bit will_fire_now(int d, int ch);
    return m_en[d][ch] && (m_period[d][ch] != 0) && (m_count[d][ch] == m_period[d][ch] - 1);
  endfunction

  // Monitor: compares read responses as the DUTs present them, plus the interrupt lines.
  always @(negedge clk) begin : monitor
    rd_t e;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      chk($sformatf("read addr %02h", e.addr), bus_data, e.exp);
    end
    chk("raise dev0", {7'd0, raise0}, {7'd0, m_raise[0]});
    chk("raise dev1", {7'd0, raise1}, {7'd0, m_raise[1]});
  end

  task automatic cyc_op(bit rst, bit we, logic [7:0] addr, logic [7:0] wd, bit ak);
    reset = rst; bus_we = we; bus_addr = addr; tb_drv = we; tb_wdata = wd; ack = ak;
    @(posedge clk);
    model_step(rst, we, addr, wd, ak);
    #1;
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) cyc_op(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  // The idle cycle keeps the bench off the bus while a prior read response is driven.
  task automatic wr(logic [7:0] addr, logic [7:0] d);
    idle(1);
    cyc_op(1'b0, 1'b1, addr, d, 1'b0);
  endtask

  task automatic rd(logic [7:0] addr);
    cyc_op(1'b0, 1'b0, addr, 8'h00, 1'b0);
  endtask

  task automatic sweep(logic [7:0] b);
    for (int k = 0; k < 16; k++) rd(b | 8'(k));
    idle(1);
  endtask

  task automatic wait_raise0(int limit, string nm);
    int k = 0;
    while (raise0 !== 1'b1 && k < limit) begin idle(1); k++; end
    n_checks++;
    if (raise0 === 1'b1) n_pass++;
    else $display("FAIL %s: raise seen %b, required 1 within %0d cycles", nm, raise0, limit);
  endtask

  task automatic hit_fire(int ch, bit do_ack, string nm);
    int k = 0;
    while (!will_fire(0, ch) && k < 200) begin idle(1); k++; end
    n_checks++;
    if (k < 200) n_pass++;
    else $display("FAIL %s: fire cycle not reached, got timeout required fire", nm);
    if (do_ack) cyc_op(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    else        cyc_op(1'b0, 1'b1, 8'hF1, 8'h01, 1'b0);
  endtask

  initial begin
    int r, dv, o;
    logic [7:0] a, d;
    reset = 1'b1; bus_we = 1'b0; bus_addr = 8'h00; tb_drv = 1'b0; tb_wdata = 8'h00; ack = 1'b0;
    for (int k = 0; k < 3; k++) cyc_op(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    sweep(8'hF0);
    sweep(8'hE0);

    // Channel 0 periodic, masked in.
    wr(8'hF4, 8'h03);
    wr(8'hF2, 8'h01);
    wr(8'hF0, 8'h11);
    wait_raise0(40, "ch0 first raise");
    cyc_op(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    idle(2);
    wait_raise0(40, "ch0 second raise");
    rd(8'hF1);
    wr(8'hF1, 8'h01);
    rd(8'hF1);
    cyc_op(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

    // Channel 1 one-shot with a 258-tick period.
    wr(8'hF6, 8'h02);
    wr(8'hF7, 8'h01);
    wr(8'hF0, 8'h02);
    idle(258 * 4 + 20);
    rd(8'hF0); rd(8'hF1); rd(8'hFD);
    idle(2000);
    rd(8'hF1); rd(8'hF0);
    wr(8'hF1, 8'h0F);

    // Channel 2 unmasked, channel 3 enabled with period 0.
    wr(8'hF8, 8'h02);
    wr(8'hF0, 8'hCC);
    idle(40);
    rd(8'hFF); rd(8'hFE); rd(8'hF1); rd(8'hF0);
    wr(8'hF1, 8'h0F);

    // W1C and ACK landing exactly on a fire edge.
    wr(8'hF0, 8'h11);
    hit_fire(0, 1'b0, "w1c on fire");
    rd(8'hF1);
    idle(1);
    hit_fire(0, 1'b1, "ack on fire");
    idle(3);
    rd(8'hF1);

    // Randomised traffic over both windows.
    for (int k = 0; k < 1500; k++) begin
      r  = $urandom_range(0, 9);
      dv = $urandom_range(0, 1);
      o  = $urandom_range(0, 15);
      a  = base[dv] | 8'(o);
      if (r < 4) begin
        rd(a);
      end else if (r < 6) begin
        if (o >= 4 && o < 12) d = (o % 2 == 1) ? 8'h00 : 8'($urandom_range(0, 6));
        else                  d = 8'($urandom_range(0, 255));
        wr(a, d);
      end else if (r == 6) begin
        cyc_op(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
      end else begin
        idle(1);
      end
    end

    // Reset in the middle of a raise with counts running.
    idle(1);
    wr(8'hF1, 8'h0F); wr(8'hE1, 8'h0F);
    wr(8'hF4, 8'h03); wr(8'hF5, 8'h00); wr(8'hF2, 8'h01); wr(8'hF0, 8'h11);
    wr(8'hE4, 8'h05); wr(8'hE5, 8'h00); wr(8'hE2, 8'h01); wr(8'hE0, 8'h11);
    wait_raise0(40, "pre-reset raise");
    idle(2);
    cyc_op(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    idle(20);
    sweep(8'hF0);
    sweep(8'hE0);

    // Two-channel instance: upper channel bits and offsets are dead.
    wr(8'hE0, 8'hFF);
    rd(8'hE0);
    idle(1);
    wr(8'hE8, 8'h55);
    rd(8'hE8); rd(8'hEE); rd(8'hE0);
    idle(3);

    n_checks++;
    if (sbq.size() == 0) n_pass++;
    else $display("FAIL scoreboard drain: got %0d pending required 0", sbq.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
